// File: rtl/sram_wb_bridge.sv
// sram_wb_bridge: turns one 32-bit Wishbone-classic word request into four
// byte accesses on the 8-bit SRAM port. Read bytes return one cycle after
// their strobe and are assembled little-endian into wb_rdt_o. The request
// is then acknowledged with a one-cycle wb_ack_o.
module sram_wb_bridge #(
  parameter int ADDR_W = 14
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              wb_cyc_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_rdt_o,
  output logic              wb_ack_o,
  output logic              sram_read_o,
  output logic              sram_write_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [7:0]        sram_wdata_o,
  input  logic [7:0]        sram_rdata_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE  = 2'd1,
    DRAIN = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [1:0]        cnt, cnt_n;

  // Request latched at acceptance; the master may change its inputs afterwards.
  logic [ADDR_W-3:0] wadr_q, wadr_n;
  logic [31:0]       dat_q, dat_n;
  logic [3:0]        sel_q, sel_n;
  logic              we_q, we_n;

  // Next values for the registered bus/SRAM outputs.
  logic              ack_n;
  logic              read_n;
  logic              write_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0]        wdata_n;

  // Read-return tracking: a strobe seen last cycle means sram_rdata_i is valid now.
  logic              cap_vld_p1;
  logic [1:0]        cap_idx_p1;

  // The low address bits are ignored: requests are always word aligned.
  logic              adr_lo_unused;
  assign adr_lo_unused = ^wb_adr_i[1:0];

  // Little-endian byte lane selection.
  function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return b;
  endfunction

  // FSM state, byte counter and latched request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      wadr_q <= '0;
      dat_q  <= '0;
      sel_q  <= '0;
      we_q   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      wadr_q <= wadr_n;
      dat_q  <= dat_n;
      sel_q  <= sel_n;
      we_q   <= we_n;
    end
  end

  // Next state, plus the output values for the cycle being entered.
  // The strobes are registered, so each byte's strobe is set up on the edge
  // that starts its BYTE cycle. Byte 0 therefore comes straight from the bus inputs.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wadr_n  = wadr_q;
    dat_n   = dat_q;
    sel_n   = sel_q;
    we_n    = we_q;
    ack_n   = 1'b0;
    read_n  = 1'b0;
    write_n = 1'b0;
    addr_n  = sram_addr_o;
    wdata_n = sram_wdata_o;
    case (state)
      IDLE: begin
        if (wb_cyc_i) begin
          state_n = BYTE;
          cnt_n   = 2'd0;
          wadr_n  = wb_adr_i[ADDR_W-1:2];
          dat_n   = wb_dat_i;
          sel_n   = wb_sel_i;
          we_n    = wb_we_i;
          addr_n  = {wb_adr_i[ADDR_W-1:2], 2'b00};
          wdata_n = wb_dat_i[7:0];
          read_n  = !wb_we_i;
          write_n = wb_we_i && wb_sel_i[0];
        end
      end
      BYTE: begin
        cnt_n = cnt + 2'd1;
        if (cnt == 2'd3) begin
          // Writes are done. Reads still wait one cycle for the last byte.
          state_n = we_q ? ACK : DRAIN;
          ack_n   = we_q;
        end else begin
          addr_n  = {wadr_q, cnt_n};
          wdata_n = byte_lane(dat_q, cnt_n);
          read_n  = !we_q;
          write_n = we_q && sel_q[cnt_n];
        end
      end
      DRAIN: begin
        state_n = ACK;
        ack_n   = 1'b1;
      end
      ACK: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Registered acknowledge and SRAM-side outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_ack_o     <= 1'b0;
      sram_read_o  <= 1'b0;
      sram_write_o <= 1'b0;
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
    end else begin
      wb_ack_o     <= ack_n;
      sram_read_o  <= read_n;
      sram_write_o <= write_n;
      sram_addr_o  <= addr_n;
      sram_wdata_o <= wdata_n;
    end
  end

  // --- stage p1: return byte arrives one cycle after its strobe ---
  // Capture the returned byte into its lane. Only cycles that follow a read
  // strobe update wb_rdt_o, so the word holds through ACK and across writes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cap_vld_p1 <= 1'b0;
      cap_idx_p1 <= 2'd0;
      wb_rdt_o   <= '0;
    end else begin
      cap_vld_p1 <= sram_read_o;
      cap_idx_p1 <= sram_addr_o[1:0];
      if (cap_vld_p1) begin
        case (cap_idx_p1)
          2'd0:    wb_rdt_o[7:0]   <= sram_rdata_i;
          2'd1:    wb_rdt_o[15:8]  <= sram_rdata_i;
          2'd2:    wb_rdt_o[23:16] <= sram_rdata_i;
          default: wb_rdt_o[31:24] <= sram_rdata_i;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sram_wb_bridge.sv
// Testbench for sram_wb_bridge. A behavioural byte SRAM with a registered
// read port sits on the SRAM side. Stimulus pushes the expected strobes and
// acks, each with its cycle number, into queues. A monitor pops and compares
// them whenever the DUT raises a strobe or wb_ack_o.
module tb_sram_wb_bridge;
  localparam int ADDR_W = 14;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b1;
  logic              wb_cyc_i = 1'b0;
  logic              wb_we_i = 1'b0;
  logic [ADDR_W-1:0] wb_adr_i = '0;
  logic [31:0]       wb_dat_i = '0;
  logic [3:0]        wb_sel_i = '0;
  logic [31:0]       wb_rdt_o;
  logic              wb_ack_o;
  logic              sram_read_o;
  logic              sram_write_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [7:0]        sram_wdata_o;
  logic [7:0]        sram_rdata_i;

  sram_wb_bridge #(.ADDR_W(ADDR_W)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .wb_cyc_i     (wb_cyc_i),
    .wb_we_i      (wb_we_i),
    .wb_adr_i     (wb_adr_i),
    .wb_dat_i     (wb_dat_i),
    .wb_sel_i     (wb_sel_i),
    .wb_rdt_o     (wb_rdt_o),
    .wb_ack_o     (wb_ack_o),
    .sram_read_o  (sram_read_o),
    .sram_write_o (sram_write_o),
    .sram_addr_o  (sram_addr_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_rdata_i (sram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int cyc_cnt = 0;
  always @(posedge clk_i) cyc_cnt++;

  typedef struct {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    int                cyc;
  } strb_t;

  typedef struct {
    logic [31:0] rdt;
    int          cyc;
  } ack_t;

  strb_t exp_strb[$];
  ack_t  exp_ack[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    t0;
  int    n_idle;

  // Byte SRAM: writes land on the edge, read data is registered.
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
    mem[14'h0104] = 8'h11;
    mem[14'h0105] = 8'h22;
    mem[14'h0106] = 8'h33;
    mem[14'h0107] = 8'h44;
    sram_rdata_i = 8'h00;
    forever begin
      @(posedge clk_i);
      if (sram_write_o === 1'b1) mem[sram_addr_o] <= sram_wdata_o;
      if (sram_read_o === 1'b1) sram_rdata_i <= mem[sram_addr_o];
    end
  end

  task automatic exp_s(input logic wr, input logic [ADDR_W-1:0] a, input logic [7:0] d, input int c);
    strb_t s;
    s.wr = wr; s.addr = a; s.data = d; s.cyc = c;
    exp_strb.push_back(s);
  endtask

  task automatic exp_a(input logic [31:0] r, input int c);
    ack_t a;
    a.rdt = r; a.cyc = c;
    exp_ack.push_back(a);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  // Drive one request from the current cycle (cycle 0) and hold it until ack.
  // Returns one edge after the ack cycle, i.e. in the first IDLE cycle.
  task automatic wb_xfer(input logic we, input logic [ADDR_W-1:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
    bit got;
    got = 1'b0;
    wb_cyc_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk_i);
      if (wb_ack_o === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout: no ack within 16 cycles for addr 0x%04h, required an ack", adr);
    end
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b0; wb_we_i = 1'b0; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
  endtask

  // Monitor: every strobe and every ack must match the next queued expectation.
  initial begin
    strb_t s;
    ack_t  a;
    forever begin
      @(negedge clk_i);
      if (sram_read_o === 1'b1 && sram_write_o === 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL strobe_excl: read=1 write=1 at cycle %0d, required at most one", cyc_cnt);
      end
      if (sram_read_o === 1'b1 || sram_write_o === 1'b1) begin
        n_checks++;
        if (exp_strb.size() == 0) begin
          n_fail++;
          $display("FAIL strobe_unexpected: wr=%0b addr=0x%04h at cycle %0d, required no strobe",
                   sram_write_o, sram_addr_o, cyc_cnt);
        end else begin
          s = exp_strb.pop_front();
          if (sram_write_o !== s.wr || sram_addr_o !== s.addr ||
              (s.wr && sram_wdata_o !== s.data) || cyc_cnt != s.cyc) begin
            n_fail++;
            $display("FAIL strobe: got wr=%0b addr=0x%04h data=0x%02h cyc=%0d, required wr=%0b addr=0x%04h data=0x%02h cyc=%0d",
                     sram_write_o, sram_addr_o, sram_wdata_o, cyc_cnt, s.wr, s.addr, s.data, s.cyc);
          end
        end
      end
      if (wb_ack_o === 1'b1) begin
        n_checks++;
        if (exp_ack.size() == 0) begin
          n_fail++;
          $display("FAIL ack_unexpected: wb_ack_o=1 at cycle %0d, required no ack", cyc_cnt);
        end else begin
          a = exp_ack.pop_front();
          if (wb_rdt_o !== a.rdt || cyc_cnt != a.cyc) begin
            n_fail++;
            $display("FAIL ack: got rdt=0x%08h cyc=%0d, required rdt=0x%08h cyc=%0d",
                     wb_rdt_o, cyc_cnt, a.rdt, a.cyc);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset asserted mid-clock: outputs clear immediately.
    repeat (2) @(posedge clk_i);
    #3 rst_ni = 1'b0;
    #1;
    chk("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("rst_read", {31'd0, sram_read_o}, 32'd0);
    chk("rst_write", {31'd0, sram_write_o}, 32'd0);
    chk("rst_rdt", wb_rdt_o, 32'd0);
    chk("rst_addr", {18'd0, sram_addr_o}, 32'd0);
    chk("rst_wdata", {24'd0, sram_wdata_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    n_idle = 0;
    repeat (5) begin
      @(negedge clk_i);
      if (sram_read_o !== 1'b0 || sram_write_o !== 1'b0 || wb_ack_o !== 1'b0) n_idle++;
    end
    chk("idle_quiet", n_idle, 32'd0);

    // Read of word 0x0104 via unaligned address 0x0107.
    @(posedge clk_i); #1;
    t0 = cyc_cnt;
    exp_s(1'b0, 14'h0104, 8'h00, t0 + 1);
    exp_s(1'b0, 14'h0105, 8'h00, t0 + 2);
    exp_s(1'b0, 14'h0106, 8'h00, t0 + 3);
    exp_s(1'b0, 14'h0107, 8'h00, t0 + 4);
    exp_a(32'h44332211, t0 + 6);
    wb_xfer(1'b0, 14'h0107, 32'h0, 4'h0);

    // Full write at the top word; no carry past the address width.
    @(posedge clk_i); #1;
    t0 = cyc_cnt;
    exp_s(1'b1, 14'h3FFC, 8'hEF, t0 + 1);
    exp_s(1'b1, 14'h3FFD, 8'hBE, t0 + 2);
    exp_s(1'b1, 14'h3FFE, 8'hAD, t0 + 3);
    exp_s(1'b1, 14'h3FFF, 8'hDE, t0 + 4);
    exp_a(32'h44332211, t0 + 5);
    wb_xfer(1'b1, 14'h3FFC, 32'hDEADBEEF, 4'hF);

    // Partial write, sel=0101: only bytes 0 and 2 strobe.
    @(posedge clk_i); #1;
    t0 = cyc_cnt;
    exp_s(1'b1, 14'h0010, 8'hDD, t0 + 1);
    exp_s(1'b1, 14'h0012, 8'hBB, t0 + 3);
    exp_a(32'h44332211, t0 + 5);
    wb_xfer(1'b1, 14'h0010, 32'hAABBCCDD, 4'b0101);

    // Read back the partially written word.
    @(posedge clk_i); #1;
    t0 = cyc_cnt;
    exp_s(1'b0, 14'h0010, 8'h00, t0 + 1);
    exp_s(1'b0, 14'h0011, 8'h00, t0 + 2);
    exp_s(1'b0, 14'h0012, 8'h00, t0 + 3);
    exp_s(1'b0, 14'h0013, 8'h00, t0 + 4);
    exp_a(32'h00BB00DD, t0 + 6);
    wb_xfer(1'b0, 14'h0010, 32'h0, 4'h0);

    // Reset in cycle 3 of a read: the read is abandoned and never acked.
    @(posedge clk_i); #1;
    t0 = cyc_cnt;
    exp_s(1'b0, 14'h0104, 8'h00, t0 + 1);
    exp_s(1'b0, 14'h0105, 8'h00, t0 + 2);
    wb_cyc_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 14'h0104;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b0;
    #1;
    chk("midrst_read", {31'd0, sram_read_o}, 32'd0);
    chk("midrst_ack", {31'd0, wb_ack_o}, 32'd0);
    chk("midrst_rdt", wb_rdt_o, 32'd0);
    chk("midrst_addr", {18'd0, sram_addr_o}, 32'd0);
    wb_cyc_i = 1'b0; wb_adr_i = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    t0 = cyc_cnt;
    exp_s(1'b0, 14'h0104, 8'h00, t0 + 1);
    exp_s(1'b0, 14'h0105, 8'h00, t0 + 2);
    exp_s(1'b0, 14'h0106, 8'h00, t0 + 3);
    exp_s(1'b0, 14'h0107, 8'h00, t0 + 4);
    exp_a(32'h44332211, t0 + 6);
    wb_xfer(1'b0, 14'h0104, 32'h0, 4'h0);

    // Back-to-back: write, then a read of the same word in the first IDLE cycle.
    @(posedge clk_i); #1;
    t0 = cyc_cnt;
    exp_s(1'b1, 14'h0200, 8'h78, t0 + 1);
    exp_s(1'b1, 14'h0201, 8'h56, t0 + 2);
    exp_s(1'b1, 14'h0202, 8'h34, t0 + 3);
    exp_s(1'b1, 14'h0203, 8'h12, t0 + 4);
    exp_a(32'h44332211, t0 + 5);
    wb_xfer(1'b1, 14'h0200, 32'h12345678, 4'hF);
    t0 = cyc_cnt;
    exp_s(1'b0, 14'h0200, 8'h00, t0 + 1);
    exp_s(1'b0, 14'h0201, 8'h00, t0 + 2);
    exp_s(1'b0, 14'h0202, 8'h00, t0 + 3);
    exp_s(1'b0, 14'h0203, 8'h00, t0 + 4);
    exp_a(32'h12345678, t0 + 6);
    wb_xfer(1'b0, 14'h0200, 32'h0, 4'h0);

    repeat (4) @(posedge clk_i);
    #1;
    chk("strobes_left", exp_strb.size(), 32'd0);
    chk("acks_left", exp_ack.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_wb_bridge.md
# sram_wb_bridge

Upstream neighbour of the byte-wide SRAM stage. It accepts 32-bit Wishbone-classic word requests from the CPU data bus and sequences each one as four single-byte accesses on the 8-bit SRAM read/write port. Read bytes are assembled into a 32-bit response and the transaction is acknowledged with a single-cycle `wb_ack_o`. Sits between the CPU bus arbiter and the SRAM read/write stage.

## Interface
Parameters:
- `ADDR_W`, 14: SRAM byte-address width; addressable space is 2^ADDR_W bytes.

Ports:
- `clk_i`  in  1  clock; all state changes on its rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `wb_cyc_i`  in  1  request valid; held high until ack.
- `wb_we_i`  in  1  1 = write, 0 = read.
- `wb_adr_i`  in  ADDR_W  byte address; bits [1:0] ignored (word aligned).
- `wb_dat_i`  in  32  write data, little-endian.
- `wb_sel_i`  in  4  byte enables for writes; ignored for reads.
- `wb_rdt_o`  out  32  read data, registered.
- `wb_ack_o`  out  1  one-cycle acknowledge, registered.
- `sram_read_o`  out  1  byte read strobe to the SRAM stage.
- `sram_write_o`  out  1  byte write strobe to the SRAM stage.
- `sram_addr_o`  out  ADDR_W  byte address.
- `sram_wdata_o`  out  8  write byte.
- `sram_rdata_i`  in  8  registered read byte from the SRAM stage; valid one cycle after `sram_read_o`.

## Operation
- States: IDLE, BYTE, DRAIN, ACK. Byte counter `cnt` is 2 bits.
- IDLE: when `wb_cyc_i`=1, latch `wb_adr_i[ADDR_W-1:2]`, `wb_dat_i`, `wb_sel_i`, `wb_we_i`, set `cnt`=0, and go to BYTE. Otherwise stay.
- BYTE, one cycle per byte:
  - `sram_addr_o` = {latched word address, `cnt`}.
  - `sram_wdata_o` = latched data[8·cnt +: 8].
  - Read: `sram_read_o`=1.
  - Write: `sram_write_o` = latched sel[cnt]. When sel[cnt]=0 the cycle is still spent, with no strobe.
  - `sram_read_o` and `sram_write_o` are never both high.
  - `cnt` increments each cycle. When `cnt`=3: reads go to DRAIN, writes go to ACK.
- Read capture:
  - `sram_rdata_i` is sampled into `wb_rdt_o[8·k +: 8]` on the edge ending the cycle after byte k's read strobe.
  - Bytes 0–2 are captured during BYTE. Byte 3 is captured at the end of DRAIN.
  - No other cycle updates `wb_rdt_o`.
- DRAIN: no strobes; go to ACK.
- ACK: `wb_ack_o`=1 for exactly one cycle, then IDLE.
  - `wb_rdt_o` holds the assembled word from ACK until the next read capture.
  - Writes leave `wb_rdt_o` unchanged.
- Master contract: `wb_cyc_i` low in the cycle after ack. Inputs other than `wb_cyc_i` are don't-care after acceptance.
- Outside BYTE, `sram_read_o`=`sram_write_o`=0. `sram_addr_o` and `sram_wdata_o` hold their last values.
- Reset (asynchronous, any state):
  - State → IDLE, `cnt`=0.
  - `wb_ack_o`, `sram_read_o`, `sram_write_o`, `wb_rdt_o`, `sram_addr_o`, `sram_wdata_o` all 0; latched request cleared.
  - An interrupted transaction is abandoned, never acked. Partially written bytes stay written.
- Address wrap: word address 0x3FFC covers bytes 0x3FFC–0x3FFF. There is no carry past ADDR_W.

## Timing
- Request sampled in cycle 0 (IDLE).
- Bytes 0–3 are issued in cycles 1–4.
- Write: `wb_ack_o` high in cycle 5. Latency 5.
- Read: capture edges end cycles 2, 3, 4, 5; `wb_ack_o` high in cycle 6 with valid `wb_rdt_o`. Latency 6.
- Back-to-back: a new `wb_cyc_i` seen in the first IDLE cycle after ACK is accepted that cycle.
- `wb_ack_o` and all SRAM-side outputs are driven from flops.

## Test plan
- Reset: hold `rst_ni`=0 mid-clock. All outputs are 0 immediately; state is IDLE. Release, then idle 5 cycles: no strobes.
- Read, SRAM preloaded 0x11, 0x22, 0x33, 0x44 at 0x0104–0x0107, `wb_adr_i`=0x0107.
  - `sram_read_o` high in cycles 1–4 with addresses 0x0104–0x0107.
  - `wb_ack_o` high in cycle 6 only, with `wb_rdt_o`=0x44332211.
- Write, `wb_dat_i`=0xDEADBEEF, sel=1111, addr 0x3FFC.
  - Write strobes in cycles 1–4 with bytes EF, BE, AD, DE to 0x3FFC–0x3FFF.
  - Ack in cycle 5; `wb_rdt_o` unchanged.
- Partial write, sel=0101, data 0xAABBCCDD over 0x00000000 at 0x0010.
  - Strobes only in cycles 1 and 3.
  - A later read returns 0x00BB00DD.
- Reset during a read: assert reset in cycle 3.
  - Strobes drop asynchronously; no ack is issued.
  - After release, a fresh read of 0x0104 completes normally with 0x44332211.
- Back-to-back: write, then a read of the same word issued the cycle after ack.
  - The read is accepted immediately and acked 6 cycles later with the written data.
